dvp_frame_gen: RTL and testbench
================================

// Module: dvp_frame_gen
// PURPOSE
//  Synthesizable DVP camera-side transmitter: emits vsync/href/byte-data frames exactly as an OV7670-class sensor does.
//  Drives format_converter in place of the real camera for on-board bring-up and closed-loop BRAM/VGA display tests.
//  Frame source is a deterministic pattern, so the framebuffer contents can be predicted byte-for-byte.
// PARAMETERS
//  H_ACTIVE    640  pixels per line
//  V_ACTIVE    480  lines per frame
//  BPP         2    bytes per pixel (RGB565, high byte first)
//  FRAME_GAP   500  idle cycles before each frame (vsync/href low)
//  VS_PRE      10   vsync-low cycles before pulse
//  VS_WIDTH    10   vsync-high cycles
//  VS_POST     100  vsync-low cycles between pulse and first href
//  H_BLANK     100  href-low cycles after every line, including the last
//  NUM_FRAMES  0    frames per start; 0 = run until stop
// PORTS
//  clk         in   1  system clock; one DVP byte per cycle
//  rst_n       in   1  asynchronous active-low reset
//  start       in   1  1-cycle pulse; begins streaming when idle
//  stop        in   1  1-cycle pulse; finish current frame, then idle
//  vsync       out  1  frame sync, active high
//  href        out  1  line valid, active high
//  dout        out  8  pixel byte, valid while href=1
//  busy        out  1  high from the cycle after accepted start until return to IDLE
//  frame_done  out  1  1-cycle pulse in last H_BLANK cycle of each frame
//  frame_cnt   out  8  frames completed since start; wraps 255->0
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, stop_pend 0; asserted mid-frame -> outputs drop to 0 immediately.
//  FSM: IDLE -> GAP(FRAME_GAP) -> VSP(VS_PRE) -> VSH(VS_WIDTH, vsync=1) -> VSQ(VS_POST) -> LINE(H_ACTIVE*BPP, href=1)
//       -> HBL(H_BLANK); HBL -> LINE while line<V_ACTIVE-1, else frame end.
//  Frame end: frame_cnt++; if stop_pend or (NUM_FRAMES!=0 and count reached NUM_FRAMES) -> IDLE, else -> GAP.
//  start accepted only in IDLE; busy=1 next cycle; frame_cnt cleared on acceptance. start while busy ignored.
//  stop sets stop_pend (sticky until IDLE); stop in IDLE ignored; start and stop same cycle in IDLE -> start wins, stop dropped.
//  All outputs registered; each state lasts exactly its parameter count; one counter (width clog2 of max span) reused per state.
//  dout: byte counter, 0 at first href byte of frame, +1 per href cycle, held during HBL, 8-bit wrap, not reset per line.
//  Byte k of frame (k counts href cycles only) = k mod 256; dout=0 outside frames.
//  href and vsync never high together; href never high outside LINE.
//  Line counter width clog2(V_ACTIVE); byte counter width clog2(H_ACTIVE*BPP); terminal compares use PARAM-1.
// CONFIGURATION
//  DVP_COLORBAR_EN defined: dout carries 8 vertical RGB565 colour bars (white,yellow,cyan,green,magenta,red,blue,black),
//   bar = pixel_x / (H_ACTIVE/8); high byte on even byte slot, low byte on odd.
//  Undefined: incrementing byte-counter pattern above.
// STRUCTURE
//  dvp_pkg: state enum (IDLE,GAP,VSP,VSH,VSQ,LINE,HBL), default timing constants, RGB565 bar colour table.
//  Sub-module dvp_pixel_src: given pixel_x, byte phase, frame-start clear -> dout; holds both pattern variants.
//  Top holds FSM, span/line counters, stop/frame bookkeeping.
// TESTING
//  Use shrunken params (H_ACTIVE=8,V_ACTIVE=4,gaps=3) plus one full 640x480 run.
//  1 start pulse, NUM_FRAMES=1 -> exact gap/vsync/href cycle counts; 4 lines x 16 href cycles; dout 0..63; frame_done once; busy falls.
//  2 NUM_FRAMES=0, stop mid-frame 2 -> frame 2 completes fully, frame_cnt=2, back to IDLE, no partial line.
//  3 start asserted while busy -> ignored, no timing glitch; start+stop same cycle in IDLE -> streams.
//  4 rst_n low mid-LINE -> vsync/href/dout/busy 0 same cycle; after release, next start gives clean frame from byte 0.
//  5 Full-size into format_converter+BRAM: 307200 wr_en pulses/frame; BRAM word n = {byte 2n, byte 2n+1} mod 256 mapped to RGB444.
//  6 DVP_COLORBAR_EN: pixel 0 = 0xFFFF, pixel 80 = 0xFFE0, pixel 639 = 0x0000; 300 frames -> frame_cnt wraps 255->0 at the 256th.

Source files
------------

// File: rtl/dvp_pkg.sv
// Shared definitions for the DVP frame generator: FSM state encoding, default
// sensor timing and the RGB565 colour-bar table used when DVP_COLORBAR_EN is set.
package dvp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_VSP,
    ST_VSH,
    ST_VSQ,
    ST_LINE,
    ST_HBL
  } dvp_state_e;

  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_BPP        = 2;
  localparam int DEF_FRAME_GAP  = 500;
  localparam int DEF_VS_PRE     = 10;
  localparam int DEF_VS_WIDTH   = 10;
  localparam int DEF_VS_POST    = 100;
  localparam int DEF_H_BLANK    = 100;
  localparam int DEF_NUM_FRAMES = 0;

  // Longest single state duration; sizes the shared span counter.
  function automatic int max_span(input int a, input int b, input int c,
                                  input int d, input int e, input int f);
    int m;
    m = 1;
    if (a > m) m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    if (f > m) m = f;
    return m;
  endfunction

  // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [15:0] bar_colour(input logic [2:0] bar);
    logic [15:0] c;
    case (bar)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dvp_pixel_src.sv
// Registered pixel-byte source for the DVP generator. Default build emits a
// per-frame incrementing byte count; DVP_COLORBAR_EN selects 8 RGB565 colour bars.
module dvp_pixel_src
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int PX_W     = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            byte_en,
  input  logic [PX_W-1:0] pixel_x,
  input  logic            byte_hi,
  output logic [7:0]      dout
);

`ifdef DVP_COLORBAR_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  int          bar_i;
  logic [2:0]  bar;
  logic [15:0] colour;
  logic [7:0]  byte_next;

  always_comb begin
    bar_i     = int'(pixel_x) / BAR_W;
    bar       = (bar_i > 7) ? 3'd7 : bar_i[2:0];
    colour    = bar_colour(bar);
    byte_next = byte_hi ? colour[15:8] : colour[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= 8'd0;
    end else if (clr) begin
      dout <= 8'd0;
    end else if (byte_en) begin
      dout <= byte_next;
    end
  end
`else
  logic [7:0] byte_cnt_reg;
  logic       unused_inputs;

  assign unused_inputs = ^{pixel_x, byte_hi};

  // Count runs across line boundaries and only restarts between frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout         <= 8'd0;
      byte_cnt_reg <= 8'd0;
    end else if (clr) begin
      dout         <= 8'd0;
      byte_cnt_reg <= 8'd0;
    end else if (byte_en) begin
      dout         <= byte_cnt_reg;
      byte_cnt_reg <= byte_cnt_reg + 8'd1;
    end
  end
`endif

endmodule

// File: rtl/dvp_frame_gen.sv
// OV7670-style DVP transmitter: vsync/href/byte frames from a deterministic pattern.
// Define DVP_COLORBAR_EN to replace the byte-count pattern with RGB565 colour bars.
module dvp_frame_gen
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int BPP        = DEF_BPP,
  parameter int FRAME_GAP  = DEF_FRAME_GAP,
  parameter int VS_PRE     = DEF_VS_PRE,
  parameter int VS_WIDTH   = DEF_VS_WIDTH,
  parameter int VS_POST    = DEF_VS_POST,
  parameter int H_BLANK    = DEF_H_BLANK,
  parameter int NUM_FRAMES = DEF_NUM_FRAMES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  output logic       vsync,
  output logic       href,
  output logic [7:0] dout,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_cnt
);

  localparam int LINE_LEN = H_ACTIVE * BPP;
  localparam int MAX_SPAN = max_span(FRAME_GAP, VS_PRE, VS_WIDTH, VS_POST, LINE_LEN, H_BLANK);
  localparam int CNT_W    = (MAX_SPAN > 1) ? $clog2(MAX_SPAN) : 1;
  localparam int LN_W     = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int PX_W     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(FRAME_GAP - 1);
  localparam logic [CNT_W-1:0] VSP_LAST  = CNT_W'(VS_PRE - 1);
  localparam logic [CNT_W-1:0] VSH_LAST  = CNT_W'(VS_WIDTH - 1);
  localparam logic [CNT_W-1:0] VSQ_LAST  = CNT_W'(VS_POST - 1);
  localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(LINE_LEN - 1);
  localparam logic [CNT_W-1:0] HBL_LAST  = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] HBL_PRE   = CNT_W'((H_BLANK > 1) ? H_BLANK - 2 : 0);
  localparam logic [LN_W-1:0]  LN_LAST   = LN_W'(V_ACTIVE - 1);
  localparam logic [7:0]       NF_LIMIT  = 8'(NUM_FRAMES);

  dvp_state_e       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [LN_W-1:0]  line_reg;
  logic             stop_pend_reg;
  logic             vsync_reg, href_reg, busy_reg, frame_done_reg;
  logic [7:0]       frame_cnt_reg;

  logic             span_last, last_line;
  logic             pix_en, pix_hold, pix_clr, byte_hi;
  logic [CNT_W-1:0] next_idx;
  logic [PX_W-1:0]  pixel_x;

  assign last_line = (line_reg == LN_LAST);

  always_comb begin
    span_last = 1'b0;
    case (state_reg)
      ST_GAP:  span_last = (cnt_reg == GAP_LAST);
      ST_VSP:  span_last = (cnt_reg == VSP_LAST);
      ST_VSH:  span_last = (cnt_reg == VSH_LAST);
      ST_VSQ:  span_last = (cnt_reg == VSQ_LAST);
      ST_LINE: span_last = (cnt_reg == LINE_LAST);
      ST_HBL:  span_last = (cnt_reg == HBL_LAST);
      default: span_last = 1'b0;
    endcase
  end

  // Look one cycle ahead so the registered dout lines up with the registered href.
  always_comb begin
    pix_en   = ((state_reg == ST_VSQ) && span_last) ||
               ((state_reg == ST_HBL) && span_last && !last_line) ||
               ((state_reg == ST_LINE) && !span_last);
    pix_hold = ((state_reg == ST_LINE) && span_last) ||
               ((state_reg == ST_HBL) && !span_last);
    pix_clr  = !pix_en && !pix_hold;
    next_idx = (state_reg == ST_LINE) ? cnt_reg + 1'b1 : '0;
    pixel_x  = PX_W'(next_idx / CNT_W'(BPP));
    byte_hi  = ((next_idx % CNT_W'(BPP)) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      line_reg       <= '0;
      stop_pend_reg  <= 1'b0;
      vsync_reg      <= 1'b0;
      href_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      frame_cnt_reg  <= 8'd0;
    end else begin
      frame_done_reg <= 1'b0;
      cnt_reg        <= cnt_reg + 1'b1;
      case (state_reg)
        ST_IDLE: begin
          cnt_reg       <= '0;
          stop_pend_reg <= 1'b0;
          if (start) begin
            state_reg     <= ST_GAP;
            busy_reg      <= 1'b1;
            frame_cnt_reg <= 8'd0;
          end
        end
        ST_GAP: if (span_last) begin
          state_reg <= ST_VSP;
          cnt_reg   <= '0;
        end
        ST_VSP: if (span_last) begin
          state_reg <= ST_VSH;
          cnt_reg   <= '0;
          vsync_reg <= 1'b1;
        end
        ST_VSH: if (span_last) begin
          state_reg <= ST_VSQ;
          cnt_reg   <= '0;
          vsync_reg <= 1'b0;
        end
        ST_VSQ: if (span_last) begin
          state_reg <= ST_LINE;
          cnt_reg   <= '0;
          line_reg  <= '0;
          href_reg  <= 1'b1;
        end
        ST_LINE: if (span_last) begin
          state_reg <= ST_HBL;
          cnt_reg   <= '0;
          href_reg  <= 1'b0;
          if (last_line && (H_BLANK == 1)) frame_done_reg <= 1'b1;
        end
        ST_HBL: begin
          if (last_line && (H_BLANK > 1) && (cnt_reg == HBL_PRE)) frame_done_reg <= 1'b1;
          if (span_last) begin
            cnt_reg <= '0;
            if (!last_line) begin
              state_reg <= ST_LINE;
              line_reg  <= line_reg + 1'b1;
              href_reg  <= 1'b1;
            end else begin
              frame_cnt_reg <= frame_cnt_reg + 8'd1;
              if (stop_pend_reg || stop ||
                  ((NUM_FRAMES != 0) && ((frame_cnt_reg + 8'd1) == NF_LIMIT))) begin
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
              end else begin
                state_reg <= ST_GAP;
              end
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
      if (stop && (state_reg != ST_IDLE)) stop_pend_reg <= 1'b1;
    end
  end

  dvp_pixel_src #(
    .H_ACTIVE (H_ACTIVE),
    .PX_W     (PX_W)
  ) u_pixel_src (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (pix_clr),
    .byte_en (pix_en),
    .pixel_x (pixel_x),
    .byte_hi (byte_hi),
    .dout    (dout)
  );

  assign vsync      = vsync_reg;
  assign href       = href_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;
  assign frame_cnt  = frame_cnt_reg;

endmodule

// File: tb/tb_dvp_frame_gen.sv
// Directed bench for dvp_frame_gen with shrunken timing (8x4 pixels, all gaps 3).
// Instance a stops after one frame by count; instance b free-runs until stop.
module tb_dvp_frame_gen;

  // One frame: GAP 3 + VSP 3 + VSH 3 + VSQ 3 + 4 lines x (16 href + 3 blank) = 88 cycles.
  localparam int FRAME_CYC = 88;

  logic       clk;
  logic       rst_n;
  logic       start_a, stop_a, start_b, stop_b;
  logic       a_vsync, a_href, a_busy, a_done;
  logic [7:0] a_dout, a_fcnt;
  logic       b_vsync, b_href, b_busy, b_done;
  logic [7:0] b_dout, b_fcnt;

  int n_chk;
  int n_fail;

  dvp_frame_gen #(
    .H_ACTIVE(8), .V_ACTIVE(4), .BPP(2), .FRAME_GAP(3), .VS_PRE(3),
    .VS_WIDTH(3), .VS_POST(3), .H_BLANK(3), .NUM_FRAMES(1)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a),
    .vsync(a_vsync), .href(a_href), .dout(a_dout), .busy(a_busy),
    .frame_done(a_done), .frame_cnt(a_fcnt)
  );

  dvp_frame_gen #(
    .H_ACTIVE(8), .V_ACTIVE(4), .BPP(2), .FRAME_GAP(3), .VS_PRE(3),
    .VS_WIDTH(3), .VS_POST(3), .H_BLANK(3), .NUM_FRAMES(0)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b),
    .vsync(b_vsync), .href(b_href), .dout(b_dout), .busy(b_busy),
    .frame_done(b_done), .frame_cnt(b_fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Byte at position pos (0..15) of line ln within a frame.
  function automatic logic [7:0] exp_byte(input int ln, input int pos);
`ifdef DVP_COLORBAR_EN
    logic [15:0] c;
    case (pos / 2)
      0: c = 16'hFFFF;  1: c = 16'hFFE0;  2: c = 16'h07FF;  3: c = 16'h07E0;
      4: c = 16'hF81F;  5: c = 16'hF800;  6: c = 16'h001F;  default: c = 16'h0000;
    endcase
    return (pos % 2 == 0) ? c[15:8] : c[7:0];
`else
    logic [7:0] b;
    b = 8'(ln * 16 + pos);
    return b;
`endif
  endfunction

  task automatic chk_idle(input bit sel, input string tag, input logic [7:0] fc);
    chk({tag, " busy"},  sel ? b_busy  : a_busy,  1'b0);
    chk({tag, " vsync"}, sel ? b_vsync : a_vsync, 1'b0);
    chk({tag, " href"},  sel ? b_href  : a_href,  1'b0);
    chk({tag, " dout"},  sel ? b_dout  : a_dout,  8'h00);
    chk({tag, " done"},  sel ? b_done  : a_done,  1'b0);
    chk({tag, " fcnt"},  sel ? b_fcnt  : a_fcnt,  fc);
    $display("txn %s: idle check, frame_cnt=%0d", tag, sel ? b_fcnt : a_fcnt);
  endtask

  task automatic pulse_start(input bit sel, input bit with_stop);
    @(posedge clk); #1;
    if (sel) begin start_b = 1'b1; stop_b = with_stop; end
    else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0; stop_b = 1'b0;
  endtask

  // Walks one frame cycle by cycle starting at its first GAP cycle; optionally
  // pulses start or stop (instance b) at a given offset.
  task automatic check_frame(input bit sel, input string tag, input int start_at, input int stop_at);
    int  u, ln, pos, n_done;
    logic e_vs, e_href, e_done, chk_dout;
    logic [7:0] e_dout;
    n_done = 0;
    for (int t = 0; t < FRAME_CYC; t++) begin
      e_vs = (t >= 6 && t < 9);
      e_href = 1'b0; e_dout = 8'h00; chk_dout = 1'b1;
      e_done = (t == FRAME_CYC - 1);
      if (t >= 12) begin
        u = t - 12; ln = u / 19; pos = u % 19;
        if (pos < 16) begin e_href = 1'b1; e_dout = exp_byte(ln, pos); end
        else chk_dout = 1'b0;
      end
      chk($sformatf("%s t=%0d vsync", tag, t), sel ? b_vsync : a_vsync, e_vs);
      chk($sformatf("%s t=%0d href", tag, t),  sel ? b_href  : a_href,  e_href);
      chk($sformatf("%s t=%0d busy", tag, t),  sel ? b_busy  : a_busy,  1'b1);
      chk($sformatf("%s t=%0d done", tag, t),  sel ? b_done  : a_done,  e_done);
      if (chk_dout) chk($sformatf("%s t=%0d dout", tag, t), sel ? b_dout : a_dout, e_dout);
      if ((sel ? b_done : a_done) === 1'b1) n_done++;
      if (sel) begin
        start_b = (t == start_at);
        stop_b  = (t == stop_at);
      end
      @(posedge clk); #1;
    end
    start_b = 1'b0; stop_b = 1'b0;
    chk({tag, " frame_done count"}, n_done, 1);
    $display("txn %s: frame of %0d cycles walked, frame_done seen %0d", tag, FRAME_CYC, n_done);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; start_a = 1'b0; stop_a = 1'b0; start_b = 1'b0; stop_b = 1'b0;

    // Reset state
    repeat (2) @(posedge clk); #1;
    chk_idle(1'b0, "reset a", 8'd0);
    chk_idle(1'b1, "reset b", 8'd0);
    rst_n = 1'b1;

    // Single frame by NUM_FRAMES=1
    pulse_start(1'b0, 1'b0);
    check_frame(1'b0, "a frame1", -1, -1);
    chk_idle(1'b0, "a after frame1", 8'd1);
    repeat (5) @(posedge clk); #1;
    chk_idle(1'b0, "a stays idle", 8'd1);

    // Free run, stop in the middle of frame 2
    pulse_start(1'b1, 1'b0);
    check_frame(1'b1, "b frame1", -1, -1);
    chk("b fcnt after frame1", b_fcnt, 8'd1);
    check_frame(1'b1, "b frame2 stop", -1, 40);
    chk_idle(1'b1, "b after stop", 8'd2);

    // Start while busy is ignored; stop early in frame 2
    pulse_start(1'b1, 1'b0);
    check_frame(1'b1, "b restart-ignored", 20, -1);
    chk("b fcnt kept", b_fcnt, 8'd1);
    check_frame(1'b1, "b frame2 early stop", -1, 5);
    chk_idle(1'b1, "b after early stop", 8'd2);

    // Start and stop together in IDLE: start wins, stream continues past frame 1
    pulse_start(1'b1, 1'b1);
    check_frame(1'b1, "b start+stop f1", -1, -1);
    chk("b still busy", b_busy, 1'b1);
    chk("b fcnt f1", b_fcnt, 8'd1);
    check_frame(1'b1, "b start+stop f2", -1, 0);
    chk_idle(1'b1, "b after start+stop", 8'd2);

    // Asynchronous reset in the middle of a line
    pulse_start(1'b0, 1'b0);
    repeat (35) @(posedge clk); #1;
    chk("a mid-line href", a_href, 1'b1);
    chk("a mid-line dout", a_dout, {24'd0, exp_byte(1, 4)});
    #2 rst_n = 1'b0;
    #1;
    chk_idle(1'b0, "a async reset", 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulse_start(1'b0, 1'b0);
    check_frame(1'b0, "a after reset", -1, -1);
    chk_idle(1'b0, "a done after reset", 8'd1);

    // frame_cnt wraps 255 -> 0 on the 256th frame
    pulse_start(1'b1, 1'b0);
    repeat (255 * FRAME_CYC) @(posedge clk); #1;
    chk("b fcnt 255", b_fcnt, 8'd255);
    chk("b busy at 255", b_busy, 1'b1);
    stop_b = 1'b1;
    @(posedge clk); #1;
    stop_b = 1'b0;
    repeat (FRAME_CYC - 1) @(posedge clk); #1;
    chk_idle(1'b1, "b wrap", 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
